// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operations and the instruction classifier.
package mcpu_pkg;

    localparam int MEM_WORDS = 4096;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR} alu_op_t;
    typedef enum logic [2:0] {K_NOP, K_JUMP, K_BRANCH, K_LOAD, K_STORE, K_ALU} kind_t;

    // Anything not recognised here falls back to K_NOP and retires after DECODE.
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        classify = K_NOP;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: classify = K_ALU;
                    FN_JR:                  classify = K_JUMP;
                    default:                classify = K_NOP;
                endcase
            end
            OP_J, OP_JAL:     classify = K_JUMP;
            OP_BEQ, OP_BNE:   classify = K_BRANCH;
            OP_ADDI, OP_XORI: classify = K_ALU;
            OP_LW:            classify = K_LOAD;
            OP_SW:            classify = K_STORE;
            default:          classify = K_NOP;
        endcase
    endfunction

    function automatic alu_op_t alu_sel(input logic [5:0] op, input logic [5:0] fn);
        alu_sel = ALU_ADD;
        if (op == OP_RTYPE) begin
            if (fn == FN_SUB)      alu_sel = ALU_SUB;
            else if (fn == FN_SLT) alu_sel = ALU_SLT;
        end else if (op == OP_XORI) begin
            alu_sel = ALU_XOR;
        end
    endfunction

endpackage

// File: rtl/mcpu_if.sv
// Observation bus of the core: program counter, instruction register,
// memory address, FSM state and memory write strobe.
interface mcpu_if;
    import mcpu_pkg::*;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] data_addr;
    state_t      state;
    logic        mem_we;

    modport master (output pc, ir, data_addr, state, mem_we);
    modport slave  (input  pc, ir, data_addr, state, mem_we);
endinterface

// File: rtl/mcpu_memory.sv
// Unified instruction/data memory, 4096 words, indexed by byte address
// bits [13:2] so the space aliases every 16 KiB. Contents survive reset.
module mcpu_memory
    import mcpu_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] data_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:MEM_WORDS-1];
    logic [11:0] idx;
    logic        unused_addr_bits;

    assign idx              = data_addr[13:2];
    assign unused_addr_bits = ^{data_addr[31:14], data_addr[1:0]};

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/mcpu_regfile.sv
// 32x32 register file: 31 resettable register cells plus a hardwired zero
// register, two combinational read ports and one write port.
module mcpu_reg32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end
endmodule

module mcpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [32];

    assign regs[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : gen1
        mcpu_reg32 greg (
            .clk   (clk),
            .reset (reset),
            .we    (we && (wa == 5'(i))),
            .d     (wd),
            .q     (regs[i])
        );
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB control FSM,
// inline ALU, register file and unified memory.
module mcpu_core
    import mcpu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    mcpu_if.master dbg
);
    state_t      state, state_nxt;
    logic [31:0] pci, pco, a, b, imm, alu_out, mdr;
    logic [31:0] rs_val, rt_val, mem_rdata, data_addr, alu_b, alu_y;
    logic [5:0]  op, fn;
    kind_t       kind;
    alu_op_t     alu_op;
    logic        rf_we, mem_we, take;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        unused_shamt;

    assign op           = pco[31:26];
    assign fn           = pco[5:0];
    assign kind         = classify(op, fn);
    assign alu_op       = alu_sel(op, fn);
    assign unused_shamt = ^pco[10:6];

    mcpu_regfile regf (
        .clk(clk), .reset(reset), .we(rf_we),
        .ra1(pco[25:21]), .ra2(pco[20:16]), .wa(rf_wa), .wd(rf_wd),
        .rd1(rs_val), .rd2(rt_val)
    );

    assign data_addr = (state == S_MEM) ? alu_out : pci;

    mcpu_memory memo (
        .clk(clk), .we(mem_we), .data_addr(data_addr), .wdata(b), .rdata(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (kind == K_NOP || kind == K_JUMP) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (kind == K_BRANCH)                         state_nxt = S_FETCH;
                else if (kind == K_LOAD || kind == K_STORE)   state_nxt = S_MEM;
                else                                          state_nxt = S_WB;
            end
            S_MEM:    state_nxt = (kind == K_LOAD) ? S_WB : S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        rf_we  = 1'b0;
        rf_wa  = pco[20:16];
        rf_wd  = alu_out;
        mem_we = 1'b0;
        case (state)
            S_DECODE: begin
                if (op == OP_JAL) begin
                    rf_we = 1'b1;
                    rf_wa = 5'd31;
                    rf_wd = pci;
                end
            end
            S_MEM: mem_we = (kind == K_STORE);
            S_WB: begin
                rf_we = 1'b1;
                rf_wa = (op == OP_RTYPE) ? pco[15:11] : pco[20:16];
                rf_wd = (kind == K_LOAD) ? mdr : alu_out;
            end
            default: ;
        endcase
        // An instruction interrupted by reset must leave no architectural trace.
        if (reset) begin
            rf_we  = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign alu_b = (op == OP_RTYPE) ? b : imm;
    assign take  = (op == OP_BEQ) ? (a == b) : (a != b);

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = a - alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(a) < $signed(alu_b)};
            ALU_XOR: alu_y = a ^ alu_b;
            default: alu_y = a + alu_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pci     <= '0;
            pco     <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    pco <= mem_rdata;
                    pci <= pci + 32'd4;
                end
                S_DECODE: begin
                    a   <= rs_val;
                    b   <= rt_val;
                    imm <= (op == OP_XORI) ? {16'h0, pco[15:0]} : {{16{pco[15]}}, pco[15:0]};
                    if (op == OP_J || op == OP_JAL) pci <= {pci[31:28], pco[25:0], 2'b00};
                    else if (kind == K_JUMP)        pci <= rs_val;
                end
                S_EXEC: begin
                    if (kind == K_BRANCH) begin
                        if (take) pci <= pci + {imm[29:0], 2'b00};
                    end else begin
                        alu_out <= alu_y;
                    end
                end
                S_MEM: begin
                    if (kind == K_LOAD) mdr <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign dbg.pc        = pci;
    assign dbg.ir        = pco;
    assign dbg.data_addr = data_addr;
    assign dbg.state     = state;
    assign dbg.mem_we    = mem_we;
endmodule

// File: tb/tb_mcpu_core.sv
// Self-checking bench for mcpu_core: per-instruction vector table, directed
// multi-cycle sequences and random programs against an instruction-level model.
module tb_mcpu_core;
    import mcpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcpu_if dbg();
    mcpu_core dut (.clk(clk), .reset(reset), .dbg(dbg));

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rv [32];
    assign rv[0] = '0;
    for (genvar g = 1; g < 32; g++) begin : g_rv
        assign rv[g] = dut.regf.gen1[g].greg.q;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
        return {op, 5'(rs), 5'(rt), im};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
        return {op, 26'(tgt)};
    endfunction

    task automatic hold_reset();
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < 4096; i++) dut.memo.mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        tick(1);
        reset = 1'b0;
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [31:0] ref_mem [4096];
    logic [31:0] ref_reg [32];
    logic [31:0] ref_pc;

    task automatic ref_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) ref_reg[r] = v;
    endtask

    task automatic ref_step(output int cyc);
        logic [31:0] ins, x, y, se, ea;
        logic [4:0]  rs, rt, rd;
        ins = ref_mem[ref_pc[13:2]];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        x = ref_reg[rs]; y = ref_reg[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ea = x + se;
        ref_pc = ref_pc + 32'd4;
        cyc = 2;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: begin ref_wr(rd, x + y); cyc = 4; end
                6'h22: begin ref_wr(rd, x - y); cyc = 4; end
                6'h2A: begin ref_wr(rd, ($signed(x) < $signed(y)) ? 32'd1 : 32'd0); cyc = 4; end
                6'h08: ref_pc = x;
                default: ;
            endcase
            6'h02: ref_pc = {ref_pc[31:28], ins[25:0], 2'b00};
            6'h03: begin ref_wr(5'd31, ref_pc); ref_pc = {ref_pc[31:28], ins[25:0], 2'b00}; end
            6'h04: begin cyc = 3; if (x == y) ref_pc = ref_pc + (se << 2); end
            6'h05: begin cyc = 3; if (x != y) ref_pc = ref_pc + (se << 2); end
            6'h08: begin ref_wr(rt, x + se); cyc = 4; end
            6'h0E: begin ref_wr(rt, x ^ {16'h0, ins[15:0]}); cyc = 4; end
            6'h23: begin ref_wr(rt, ref_mem[ea[13:2]]); cyc = 5; end
            6'h2B: begin ref_mem[ea[13:2]] = y; cyc = 4; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        k  = $urandom_range(0, 12);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        case (k)
            0:  return enc_i(OP_ADDI, rs, rt, 16'($urandom()));
            1:  return enc_i(OP_XORI, rs, rt, 16'($urandom()));
            2:  return enc_r(rs, rt, rd, FN_ADD);
            3:  return enc_r(rs, rt, rd, FN_SUB);
            4:  return enc_r(rs, rt, rd, FN_SLT);
            5:  return enc_i(OP_LW, 0, rt, 16'(32'h2000 + 4 * $urandom_range(0, 15)));
            6:  return enc_i(OP_SW, 0, rt, 16'(32'h2000 + 4 * $urandom_range(0, 15)));
            7:  return enc_i(OP_BEQ, rs, rt, 16'(int'($urandom_range(0, 6)) - 3));
            8:  return enc_i(OP_BNE, rs, rt, 16'(int'($urandom_range(0, 6)) - 3));
            9:  return enc_j(OP_J, $urandom_range(0, 39));
            10: return enc_j(OP_JAL, $urandom_range(0, 39));
            11: return enc_r(rs, 0, 0, FN_JR);
            default: return $urandom();
        endcase
    endfunction

    // ---------------- per-instruction vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] va;
        logic [31:0] vb;
        int          dreg;
        logic [31:0] dval;
        logic [31:0] pc;
        int          cyc;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int cyc, total, mism;

        vecs[0]  = '{enc_r(1, 2, 3, FN_ADD), 32'd7, 32'd5, 3, 32'd12, 32'd12, 4};
        vecs[1]  = '{enc_r(1, 2, 3, FN_SUB), 32'd5, 32'd7, 3, 32'hFFFF_FFFE, 32'd12, 4};
        vecs[2]  = '{enc_r(1, 2, 3, FN_SLT), 32'hFFFF_FFFF, 32'd1, 3, 32'd1, 32'd12, 4};
        vecs[3]  = '{enc_r(1, 2, 3, FN_SLT), 32'd1, 32'hFFFF_FFFF, 3, 32'd0, 32'd12, 4};
        vecs[4]  = '{enc_r(1, 2, 3, FN_ADD), 32'hFFFF_FFFF, 32'd2, 3, 32'd1, 32'd12, 4};
        vecs[5]  = '{enc_i(OP_ADDI, 1, 3, 16'hFFFF), 32'd10, 32'd0, 3, 32'd9, 32'd12, 4};
        vecs[6]  = '{enc_i(OP_XORI, 1, 3, 16'hFFFF), 32'h1234_5678, 32'd0, 3, 32'h1234_A987, 32'd12, 4};
        vecs[7]  = '{enc_i(OP_BEQ, 1, 2, 16'h0002), 32'd3, 32'd3, 3, 32'd0, 32'd20, 3};
        vecs[8]  = '{enc_i(OP_BEQ, 1, 2, 16'h0002), 32'd3, 32'd4, 3, 32'd0, 32'd12, 3};
        vecs[9]  = '{enc_i(OP_BNE, 1, 2, 16'h0002), 32'd3, 32'd4, 3, 32'd0, 32'd20, 3};
        vecs[10] = '{enc_i(OP_BNE, 1, 2, 16'h0002), 32'd3, 32'd3, 3, 32'd0, 32'd12, 3};
        vecs[11] = '{enc_i(OP_BEQ, 1, 2, 16'hFFFE), 32'd3, 32'd3, 3, 32'd0, 32'd4, 3};
        vecs[12] = '{enc_j(OP_J, 10), 32'd1, 32'd2, 3, 32'd0, 32'd40, 2};
        vecs[13] = '{enc_j(OP_JAL, 10), 32'd1, 32'd2, 31, 32'd12, 32'd40, 2};
        vecs[14] = '{enc_r(1, 0, 0, FN_JR), 32'h100, 32'd2, 3, 32'd0, 32'h100, 2};
        vecs[15] = '{32'hFC00_0000, 32'd1, 32'd2, 3, 32'd0, 32'd12, 2};
        vecs[16] = '{enc_r(1, 2, 3, 6'h21), 32'd7, 32'd5, 3, 32'd0, 32'd12, 2};
        vecs[17] = '{enc_i(OP_ADDI, 1, 1, 16'h8000), 32'd0, 32'd0, 1, 32'hFFFF_8000, 32'd12, 4};
        vecs[18] = '{enc_r(1, 2, 3, FN_SLT), 32'd5, 32'd5, 3, 32'd0, 32'd12, 4};

        for (int i = 0; i < 19; i++) begin
            hold_reset();
            dut.memo.mem[0]    = enc_i(OP_LW, 0, 1, 16'h2000);
            dut.memo.mem[1]    = enc_i(OP_LW, 0, 2, 16'h2004);
            dut.memo.mem[2]    = vecs[i].instr;
            dut.memo.mem[2048] = vecs[i].va;
            dut.memo.mem[2049] = vecs[i].vb;
            release_reset();
            tick(10 + vecs[i].cyc - 1);
            chk($sformatf("vec%0d still busy", i), {31'b0, dbg.state == S_FETCH}, 32'd0);
            tick(1);
            chk($sformatf("vec%0d state", i), 32'(dbg.state), 32'(S_FETCH));
            chk($sformatf("vec%0d pc", i), dut.pci, vecs[i].pc);
            chk($sformatf("vec%0d reg", i), rv[vecs[i].dreg], vecs[i].dval);
        end

        // reset values and first fetch
        hold_reset();
        dut.memo.mem[0] = enc_i(OP_ADDI, 0, 2, 16'd5);
        chk("reset pci", dut.pci, 32'd0);
        chk("reset pco", dut.pco, 32'd0);
        chk("reset state", 32'(dbg.state), 32'(S_FETCH));
        for (int r = 1; r < 32; r++) chk($sformatf("reset r%0d", r), rv[r], 32'd0);
        release_reset();
        tick(1);
        chk("first fetch pci", dut.pci, 32'd4);
        chk("first fetch pco", dut.pco, enc_i(OP_ADDI, 0, 2, 16'd5));
        tick(3);
        chk("addi r2", rv[2], 32'd5);

        // store / load / add through the data segment
        hold_reset();
        dut.memo.mem[0] = enc_i(OP_ADDI, 0, 2, 16'd5);
        dut.memo.mem[1] = enc_i(OP_ADDI, 0, 8, 16'h2000);
        dut.memo.mem[2] = enc_i(OP_SW, 8, 2, 16'h0000);
        dut.memo.mem[3] = enc_i(OP_LW, 8, 9, 16'h0000);
        dut.memo.mem[4] = enc_r(2, 9, 2, FN_ADD);
        release_reset();
        tick(8 + 3);
        chk("sw in mem state", 32'(dbg.state), 32'(S_MEM));
        chk("sw data_addr", dut.memo.data_addr, 32'h2000);
        tick(1);
        chk("sw mem[2048]", dut.memo.mem[2048], 32'd5);
        tick(5);
        chk("lw r9", rv[9], 32'd5);
        tick(4);
        chk("add r2", rv[2], 32'd10);

        // JAL / JR round trip
        hold_reset();
        dut.memo.mem[0]  = enc_j(OP_JAL, 10);
        dut.memo.mem[1]  = enc_i(OP_ADDI, 0, 4, 16'd1);
        dut.memo.mem[10] = enc_r(31, 0, 0, FN_JR);
        release_reset();
        tick(2);
        chk("jal r31", rv[31], 32'd4);
        chk("jal pc", dut.pci, 32'd40);
        tick(2);
        chk("jr pc", dut.pci, 32'd4);
        tick(4);
        chk("after return r4", rv[4], 32'd1);

        // sum loop, XORI zero extension, $0 immutability
        hold_reset();
        dut.memo.mem[0]  = enc_i(OP_ADDI, 0, 1, 16'd1);
        dut.memo.mem[1]  = enc_i(OP_ADDI, 0, 2, 16'd0);
        dut.memo.mem[2]  = enc_i(OP_ADDI, 0, 5, 16'd11);
        dut.memo.mem[3]  = enc_r(2, 1, 2, FN_ADD);
        dut.memo.mem[4]  = enc_i(OP_ADDI, 1, 1, 16'd1);
        dut.memo.mem[5]  = enc_r(1, 5, 6, FN_SLT);
        dut.memo.mem[6]  = enc_i(OP_BNE, 6, 0, 16'hFFFC);
        dut.memo.mem[7]  = enc_i(OP_XORI, 2, 3, 16'hFFFF);
        dut.memo.mem[8]  = enc_i(OP_ADDI, 0, 7, 16'hFFFF);
        dut.memo.mem[9]  = enc_i(OP_XORI, 7, 4, 16'hFFFF);
        dut.memo.mem[10] = enc_i(OP_ADDI, 0, 0, 16'd7);
        dut.memo.mem[11] = enc_r(0, 0, 5, FN_ADD);
        dut.memo.mem[12] = enc_j(OP_J, 12);
        release_reset();
        tick(230);
        chk("loop sum r2", rv[2], 32'd55);
        chk("xori small r3", rv[3], 32'h0000_FFC8);
        chk("xori zext r4", rv[4], 32'hFFFF_0000);
        chk("r0 stays zero", rv[5], 32'd0);

        // reset landing on the MEM edge of a store
        hold_reset();
        dut.memo.mem[0]    = enc_i(OP_ADDI, 0, 2, 16'd5);
        dut.memo.mem[1]    = enc_i(OP_ADDI, 0, 8, 16'h2000);
        dut.memo.mem[2]    = enc_i(OP_SW, 8, 2, 16'h0000);
        dut.memo.mem[2048] = 32'hDEAD_BEEF;
        release_reset();
        tick(8 + 3);
        chk("pre-abort state", 32'(dbg.state), 32'(S_MEM));
        reset = 1'b1;
        tick(1);
        chk("abort mem kept", dut.memo.mem[2048], 32'hDEAD_BEEF);
        chk("abort pci", dut.pci, 32'd0);
        chk("abort state", 32'(dbg.state), 32'(S_FETCH));

        // random programs against the instruction-level model
        for (int run = 0; run < 20; run++) begin
            hold_reset();
            for (int w = 0; w < 4096; w++) ref_mem[w] = 32'h0;
            for (int w = 0; w < 40; w++) ref_mem[w] = rand_instr();
            for (int w = 2048; w < 2064; w++) ref_mem[w] = $urandom();
            for (int r = 0; r < 32; r++) ref_reg[r] = 32'h0;
            ref_pc = 32'h0;
            for (int w = 0; w < 4096; w++) dut.memo.mem[w] = ref_mem[w];
            release_reset();
            total = 0;
            for (int n = 0; n < 60; n++) begin
                ref_step(cyc);
                total += cyc;
            end
            tick(total);
            chk($sformatf("rand%0d state", run), 32'(dbg.state), 32'(S_FETCH));
            chk($sformatf("rand%0d pc", run), dut.pci, ref_pc);
            for (int r = 1; r < 32; r++)
                chk($sformatf("rand%0d r%0d", run, r), rv[r], ref_reg[r]);
            mism = 0;
            for (int w = 0; w < 4096; w++)
                if (dut.memo.mem[w] !== ref_mem[w]) mism++;
            chk($sformatf("rand%0d mem words differing", run), 32'(mism), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
